gen_datapath: RTL and testbench

- Parametrised successor of the CPU datapath: register file, A/B operand registers, shifter, ALU, C result register and status register, generalised in width and register count.
- Adds an internal micro-sequencer: one accepted command runs read-A, read-B, execute and write-back autonomously, with a valid/ready handshake and a done pulse.
- Adds a carry flag and a host load port.
- Sits between the instruction FSM and memory; the FSM issues one command per instruction instead of driving per-cycle enables.

---
 rtl/gen_datapath_pkg.sv | 19 +
 rtl/gen_datapath_if.sv | 35 +++
 rtl/gen_regfile.sv | 30 +++
 rtl/gen_datapath.sv | 201 ++++++++++++++++++++
 tb/tb_gen_datapath.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_datapath_pkg.sv
// Shared types for gen_datapath: sequencer states, command field encodings and status flags.
package gen_datapath_pkg;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOTB} alu_op_t;

  typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_op_t;

  typedef enum logic [1:0] {WB_C, WB_PC, WB_IMM, WB_MDATA} wb_sel_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/gen_datapath_if.sv
// Command handshake bundle between the instruction FSM (master) and gen_datapath (slave).
interface gen_datapath_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_rn;
  logic [AW-1:0]    cmd_rm;
  logic [AW-1:0]    cmd_rd;
  logic [1:0]       cmd_alu_op;
  logic [1:0]       cmd_shift_op;
  logic             cmd_zero_a;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;
  logic [1:0]       cmd_wb_sel;
  logic             cmd_wb_en;
  logic             cmd_set_status;
  logic             done;

  modport master (
    output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_alu_op, cmd_shift_op,
           cmd_zero_a, cmd_use_imm, cmd_imm, cmd_wb_sel, cmd_wb_en, cmd_set_status,
    input  cmd_ready, done
  );

  modport slave (
    input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_alu_op, cmd_shift_op,
           cmd_zero_a, cmd_use_imm, cmd_imm, cmd_wb_sel, cmd_wb_en, cmd_set_status,
    output cmd_ready, done
  );

endinterface

// File: rtl/gen_regfile.sv
// Register file: one write port, two combinational read ports (read-before-write), async clear.
module gen_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]         o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]         o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/gen_datapath.sv
// Parametrised datapath with a micro-sequencer: each accepted command runs
// read-A, read-B, execute and write-back, then pulses done.
module gen_datapath
  import gen_datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gen_datapath_if.slave            cmd,
  input  logic [WIDTH-1:0]         mdata,
  input  logic [PCW-1:0]           pc,
  input  logic                     ld_en,
  input  logic [$clog2(NREGS)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic [WIDTH-1:0]         datapath_out,
  output logic                     Z_out,
  output logic                     N_out,
  output logic                     V_out,
  output logic                     C_out
);

  localparam int AW  = $clog2(NREGS);
  localparam int MSB = WIDTH - 1;

  state_t           r_state, w_next;
  logic             w_ready, w_done, w_accept;

  logic [AW-1:0]    r_rn, r_rm, r_rd;
  alu_op_t          r_alu_op;
  shift_op_t        r_shift_op;
  wb_sel_t          r_wb_sel;
  logic             r_zero_a, r_use_imm, r_wb_en, r_set_status;
  logic [WIDTH-1:0] r_imm;

  logic [WIDTH-1:0] r_a, r_b, r_c;
  flags_t           r_flags;

  logic [WIDTH-1:0] w_rd_a, w_rd_b, w_shifted, w_val_a, w_val_b, w_res, w_wb_src;
  logic [WIDTH:0]   w_sum;
  logic             w_cout, w_ovf;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  assign w_accept = (r_state == IDLE) && cmd.cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (cmd.cmd_valid) w_next = RD_A;
      end
      RD_A:    w_next = RD_B;
      RD_B:    w_next = EXEC;
      EXEC:    w_next = WB;
      WB: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign cmd.cmd_ready = w_ready;
  assign cmd.done      = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rn         <= '0;
      r_rm         <= '0;
      r_rd         <= '0;
      r_alu_op     <= ALU_ADD;
      r_shift_op   <= SH_NONE;
      r_wb_sel     <= WB_C;
      r_zero_a     <= 1'b0;
      r_use_imm    <= 1'b0;
      r_wb_en      <= 1'b0;
      r_set_status <= 1'b0;
      r_imm        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_flags      <= '0;
    end else begin
      if (w_accept) begin
        r_rn         <= cmd.cmd_rn;
        r_rm         <= cmd.cmd_rm;
        r_rd         <= cmd.cmd_rd;
        r_alu_op     <= alu_op_t'(cmd.cmd_alu_op);
        r_shift_op   <= shift_op_t'(cmd.cmd_shift_op);
        r_wb_sel     <= wb_sel_t'(cmd.cmd_wb_sel);
        r_zero_a     <= cmd.cmd_zero_a;
        r_use_imm    <= cmd.cmd_use_imm;
        r_wb_en      <= cmd.cmd_wb_en;
        r_set_status <= cmd.cmd_set_status;
        r_imm        <= cmd.cmd_imm;
      end
      if (r_state == RD_A) r_a <= w_rd_a;
      if (r_state == RD_B) r_b <= w_rd_b;
      if (r_state == EXEC) begin
        r_c <= w_res;
        if (r_set_status) r_flags <= '{z: (w_res == '0), n: w_res[MSB], v: w_ovf, c: w_cout};
      end
    end
  end

  always_comb begin
    w_shifted = r_b;
    case (r_shift_op)
      SH_LSL1: w_shifted = {r_b[MSB-1:0], 1'b0};
      SH_LSR1: w_shifted = {1'b0, r_b[MSB:1]};
      SH_ASR1: w_shifted = {r_b[MSB], r_b[MSB:1]};
      default: w_shifted = r_b;
    endcase
  end

  assign w_val_a = r_zero_a  ? '0    : r_a;
  assign w_val_b = r_use_imm ? r_imm : w_shifted;

  // SUB is a + ~b + 1, so the carry out is already the inverted borrow.
  always_comb begin
    w_sum  = '0;
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (r_alu_op)
      ALU_ADD: begin
        w_sum  = {1'b0, w_val_a} + {1'b0, w_val_b};
        w_res  = w_sum[MSB:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (w_val_a[MSB] == w_val_b[MSB]) && (w_res[MSB] != w_val_a[MSB]);
      end
      ALU_SUB: begin
        w_sum  = {1'b0, w_val_a} + {1'b0, ~w_val_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res  = w_sum[MSB:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (w_val_a[MSB] != w_val_b[MSB]) && (w_res[MSB] != w_val_a[MSB]);
      end
      ALU_AND:  w_res = w_val_a & w_val_b;
      ALU_NOTB: w_res = ~w_val_b;
      default:  w_res = '0;
    endcase
  end

  always_comb begin
    w_wb_src = r_c;
    case (r_wb_sel)
      WB_PC:    w_wb_src = WIDTH'(pc);
      WB_IMM:   w_wb_src = r_imm;
      WB_MDATA: w_wb_src = mdata;
      default:  w_wb_src = r_c;
    endcase
  end

  // Write-back owns the port in WB; host loads only land while idle with no command offered.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = ld_addr;
    w_wdata = ld_data;
    if (r_state == WB) begin
      w_we    = r_wb_en;
      w_waddr = r_rd;
      w_wdata = w_wb_src;
    end else if (r_state == IDLE && !cmd.cmd_valid) begin
      w_we    = ld_en;
    end
  end

  gen_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_rn),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (r_rm),
    .o_rdata_b (w_rd_b)
  );

  assign datapath_out = r_c;
  assign Z_out        = r_flags.z;
  assign N_out        = r_flags.n;
  assign V_out        = r_flags.v;
  assign C_out        = r_flags.c;

endmodule

// File: tb/tb_gen_datapath.sv
// Directed bench for gen_datapath: vector table for the 16-bit instance plus
// hand-written throughput, busy-load, mid-command reset and 32-bit sequences.
module tb_gen_datapath;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gen_datapath_if #(.WIDTH(16), .NREGS(8))  if16();
  gen_datapath_if #(.WIDTH(32), .NREGS(16)) if32();

  logic [15:0] mdata16, ld_data16, dout16;
  logic [7:0]  pc16;
  logic        ld_en16, z16, n16, v16, c16;
  logic [2:0]  ld_addr16;

  logic [31:0] mdata32, ld_data32, dout32;
  logic [7:0]  pc32;
  logic        ld_en32, z32, n32, v32, c32;
  logic [3:0]  ld_addr32;

  gen_datapath #(.WIDTH(16), .NREGS(8), .PCW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(if16), .mdata(mdata16), .pc(pc16),
    .ld_en(ld_en16), .ld_addr(ld_addr16), .ld_data(ld_data16), .datapath_out(dout16),
    .Z_out(z16), .N_out(n16), .V_out(v16), .C_out(c16)
  );

  gen_datapath #(.WIDTH(32), .NREGS(16), .PCW(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .cmd(if32), .mdata(mdata32), .pc(pc32),
    .ld_en(ld_en32), .ld_addr(ld_addr32), .ld_data(ld_data32), .datapath_out(dout32),
    .Z_out(z32), .N_out(n32), .V_out(v32), .C_out(c32)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // l1/l2: optional host loads before the command; exp_f = {Z,N,V,C}
  typedef struct {
    int l1v, l1a, l1d, l2v, l2a, l2d;
    int rn, rm, rd, alu, sh, za, ui, imm, wbs, wbe, ss, md, pcv;
    int exp_c, exp_f, exp_r;
  } vec_t;

  vec_t vecs[12];

  task automatic load16(input int a, input int d);
    @(negedge clk);
    ld_en16 = 1'b1; ld_addr16 = 3'(a); ld_data16 = 16'(d);
    @(negedge clk);
    ld_en16 = 1'b0;
  endtask

  task automatic drive16(input vec_t v);
    if16.cmd_rn = 3'(v.rn);   if16.cmd_rm = 3'(v.rm);   if16.cmd_rd = 3'(v.rd);
    if16.cmd_alu_op = 2'(v.alu); if16.cmd_shift_op = 2'(v.sh);
    if16.cmd_zero_a = 1'(v.za); if16.cmd_use_imm = 1'(v.ui); if16.cmd_imm = 16'(v.imm);
    if16.cmd_wb_sel = 2'(v.wbs); if16.cmd_wb_en = 1'(v.wbe); if16.cmd_set_status = 1'(v.ss);
    mdata16 = 16'(v.md); pc16 = 8'(v.pcv);
  endtask

  task automatic scramble16();
    if16.cmd_rn = 3'($urandom);  if16.cmd_rm = 3'($urandom);  if16.cmd_rd = 3'($urandom);
    if16.cmd_alu_op = 2'($urandom); if16.cmd_shift_op = 2'($urandom);
    if16.cmd_zero_a = 1'($urandom); if16.cmd_use_imm = 1'($urandom);
    if16.cmd_imm = 16'($urandom); if16.cmd_wb_sel = 2'($urandom);
    if16.cmd_wb_en = 1'($urandom); if16.cmd_set_status = 1'($urandom);
  endtask

  // Handshake one command, junk the fields while busy, return cycles from handshake to done.
  task automatic run16(input vec_t v, output int lat);
    @(negedge clk);
    drive16(v);
    if16.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !if16.cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    if16.cmd_valid = 1'b0;
    scramble16();
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if16.done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic load32(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en32 = 1'b1; ld_addr32 = 4'(a); ld_data32 = d;
    @(negedge clk);
    ld_en32 = 1'b0;
  endtask

  task automatic run32(input int rn, input int rm, input int rd, output int lat);
    @(negedge clk);
    if32.cmd_rn = 4'(rn); if32.cmd_rm = 4'(rm); if32.cmd_rd = 4'(rd);
    if32.cmd_alu_op = 2'b00; if32.cmd_shift_op = 2'b00; if32.cmd_zero_a = 1'b0;
    if32.cmd_use_imm = 1'b0; if32.cmd_wb_sel = 2'b00; if32.cmd_wb_en = 1'b1;
    if32.cmd_set_status = 1'b1;
    if32.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !if32.cmd_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    if32.cmd_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if32.done) break;
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int hs[4];
    int k;
    logic any_done;
    vec_t rv;

    //          l1v l1a l1d      l2v l2a l2d     rn rm rd alu sh za ui imm      wbs wbe ss md       pcv    exp_c    exp_f  exp_r
    vecs[0]  = '{1, 1, 'h5,    1, 2, 'h3,    1, 2, 3, 0, 0, 0, 0, 0,      0, 1, 1, 0,      0,     'h0008, 'b0000, 'h0008};
    vecs[1]  = '{1, 1, 'h7FFF, 1, 2, 'h1,    1, 2, 4, 0, 0, 0, 0, 0,      0, 1, 1, 0,      0,     'h8000, 'b0110, 'h8000};
    vecs[2]  = '{0, 0, 0,      0, 0, 0,      1, 1, 5, 1, 0, 0, 0, 0,      0, 1, 1, 0,      0,     'h0000, 'b1001, 'h0000};
    vecs[3]  = '{1, 2, 'h8002, 0, 0, 0,      1, 2, 3, 3, 3, 1, 0, 0,      0, 1, 1, 0,      0,     'h3FFE, 'b0000, 'h3FFE};
    vecs[4]  = '{0, 0, 0,      0, 0, 0,      1, 2, 3, 3, 2, 1, 0, 0,      0, 1, 1, 0,      0,     'hBFFE, 'b0100, 'hBFFE};
    vecs[5]  = '{0, 0, 0,      0, 0, 0,      1, 2, 7, 0, 0, 0, 0, 0,      3, 1, 0, 'hBEEF, 0,     'h0001, 'b0100, 'hBEEF};
    vecs[6]  = '{0, 0, 0,      0, 0, 0,      1, 2, 6, 2, 0, 0, 0, 0,      1, 1, 0, 0,      'h42,  'h0002, 'b0100, 'h0042};
    vecs[7]  = '{0, 0, 0,      0, 0, 0,      0, 0, 5, 0, 0, 1, 1, 'h1234, 2, 1, 1, 0,      0,     'h1234, 'b0000, 'h1234};
    vecs[8]  = '{0, 0, 0,      0, 0, 0,      2, 1, 0, 1, 0, 0, 0, 0,      0, 0, 1, 0,      0,     'h0003, 'b0011, 'h0000};
    vecs[9]  = '{0, 0, 0,      0, 0, 0,      0, 1, 4, 0, 1, 1, 0, 0,      0, 1, 1, 0,      0,     'hFFFE, 'b0100, 'hFFFE};
    vecs[10] = '{0, 0, 0,      0, 0, 0,      0, 0, 1, 1, 0, 0, 1, 'h0001, 0, 0, 1, 0,      0,     'hFFFF, 'b0100, 'h7FFF};
    vecs[11] = '{0, 0, 0,      0, 0, 0,      4, 2, 3, 0, 0, 0, 0, 0,      0, 1, 1, 0,      0,     'h8000, 'b0101, 'h8000};

    rst_n = 1'b0;
    if16.cmd_valid = 1'b0; if32.cmd_valid = 1'b0;
    rv = vecs[0];
    drive16(rv);
    if32.cmd_rn = '0; if32.cmd_rm = '0; if32.cmd_rd = '0; if32.cmd_alu_op = '0;
    if32.cmd_shift_op = '0; if32.cmd_zero_a = 1'b0; if32.cmd_use_imm = 1'b0;
    if32.cmd_imm = '0; if32.cmd_wb_sel = '0; if32.cmd_wb_en = 1'b0; if32.cmd_set_status = 1'b0;
    ld_en16 = 1'b0; ld_addr16 = '0; ld_data16 = '0;
    ld_en32 = 1'b0; ld_addr32 = '0; ld_data32 = '0; mdata32 = '0; pc32 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ready", 32'(if16.cmd_ready), 32'd1);
    chk("reset_done",  32'(if16.done), 32'd0);
    chk("reset_dout",  32'(dout16), 32'd0);
    chk("reset_flags", 32'({z16, n16, v16, c16}), 32'd0);

    for (int i = 0; i < 12; i++) begin
      rv = vecs[i];
      if (rv.l1v != 0) load16(rv.l1a, rv.l1d);
      if (rv.l2v != 0) load16(rv.l2a, rv.l2d);
      run16(rv, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_dout", i), 32'(dout16), 32'(rv.exp_c));
      chk($sformatf("v%0d_flags", i), 32'({z16, n16, v16, c16}), 32'(rv.exp_f));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_clear", i), 32'(if16.done), 32'd0);
      chk($sformatf("v%0d_ready", i), 32'(if16.cmd_ready), 32'd1);
      chk($sformatf("v%0d_reg", i), 32'(dut.u_rf.r_mem[rv.rd]), 32'(rv.exp_r));
    end

    // valid held high: accepts every 5 cycles; ld_en throughout must never land
    rv = '{0,0,0,0,0,0, 0,0,0, 0,0,1,0,0, 0,0,0, 0,0, 0,0,0};
    @(negedge clk);
    drive16(rv);
    if16.cmd_valid = 1'b1;
    ld_en16 = 1'b1; ld_addr16 = 3'd5; ld_data16 = 16'hDEAD;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (if16.cmd_ready && k < 4) begin
        hs[k] = c;
        k++;
      end
      @(negedge clk);
    end
    if16.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !if16.cmd_ready; i++) @(negedge clk);
    ld_en16 = 1'b0;
    chk("tput_accepts", 32'(k), 32'd4);
    if (k >= 3) begin
      chk("tput_gap1", 32'(hs[1] - hs[0]), 32'd5);
      chk("tput_gap2", 32'(hs[2] - hs[1]), 32'd5);
    end
    chk("busy_load_dropped", 32'(dut.u_rf.r_mem[5]), 32'h1234);

    // reset asserted in EXEC aborts the command
    rv = '{0,0,0,0,0,0, 1,2,3, 0,0,0,0,0, 0,1,1, 0,0, 0,0,0};
    load16(3, 'h0055);
    @(negedge clk);
    drive16(rv);
    if16.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if16.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done |= if16.done;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      any_done |= if16.done;
    end
    chk("rst_no_done", 32'(any_done), 32'd0);
    chk("rst_ready",   32'(if16.cmd_ready), 32'd1);
    chk("rst_flags",   32'({z16, n16, v16, c16}), 32'd0);
    chk("rst_dout",    32'(dout16), 32'd0);
    chk("rst_rd_zero", 32'(dut.u_rf.r_mem[3]), 32'd0);

    // 32-bit, 16-register instance
    load32(1, 32'd5);
    load32(2, 32'd3);
    run32(1, 2, 3, lat);
    chk("w32_latency", 32'(lat), 32'd4);
    chk("w32_dout",    dout32, 32'd8);
    chk("w32_flags",   32'({z32, n32, v32, c32}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w32_reg",     dut32.u_rf.r_mem[3], 32'd8);
    load32(14, 32'h7FFF_FFFF);
    load32(15, 32'h0000_0001);
    run32(14, 15, 13, lat);
    chk("w32_ovf_dout",  dout32, 32'h8000_0000);
    chk("w32_ovf_flags", 32'({z32, n32, v32, c32}), 32'b0110);
    @(posedge clk);
    @(negedge clk);
    chk("w32_ovf_reg",   dut32.u_rf.r_mem[13], 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
